prio_arbiter: RTL and testbench

//  Parametrised, registered successor to the 4:2 priority encoder. Picks one of N

---
 rtl/prio_arbiter.sv | 111 +++++++++++
 tb/tb_prio_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter.sv
// Registered N-way request arbiter: fixed priority (MSB wins) or descending round-robin.
// Each grant is held with a valid/ack handshake until the consumer accepts it.
module prio_arbiter #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ack,
  output logic         gnt_vld,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         busy
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t         r_state,  w_state_nxt;
  logic           r_vld,    w_vld_nxt;
  logic [W-1:0]   r_idx,    w_idx_nxt;
  logic [N-1:0]   r_onehot, w_onehot_nxt;
  logic [W-1:0]   r_ptr,    w_ptr_nxt;
  logic           r_rr,     w_rr_nxt;
  logic [W-1:0]   w_fix_idx;
  logic [W-1:0]   w_rr_idx;
  logic [W-1:0]   w_win;

  // Fixed priority: the last set bit scanned upward is the highest one
  always_comb begin
    w_fix_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[W'(i)]) w_fix_idx = W'(i);
    end
  end

  // Round-robin: first set bit searching ptr, ptr-1, ... wrapping modulo N
  always_comb begin
    int unsigned pos;
    logic        hit;
    pos      = 0;
    hit      = 1'b0;
    w_rr_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = (32'(r_ptr) + N - off) % N;
      if (!hit && req[W'(pos)]) begin
        w_rr_idx = W'(pos);
        hit      = 1'b1;
      end
    end
  end

  assign w_win = mode ? w_rr_idx : w_fix_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_vld    <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= W'(N - 1);
      r_rr     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld    <= w_vld_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rr     <= w_rr_nxt;
    end
  end

  // r_rr remembers the mode the grant was issued in, so ack advances ptr only for RR grants
  always_comb begin
    w_state_nxt  = r_state;
    w_vld_nxt    = r_vld;
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    w_ptr_nxt    = r_ptr;
    w_rr_nxt     = r_rr;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt         = ST_GRANT;
          w_vld_nxt           = 1'b1;
          w_idx_nxt           = w_win;
          w_onehot_nxt        = '0;
          w_onehot_nxt[w_win] = 1'b1;
          w_rr_nxt            = mode;
        end
      end
      ST_GRANT: begin
        if (gnt_ack) begin
          w_state_nxt  = ST_IDLE;
          w_vld_nxt    = 1'b0;
          w_idx_nxt    = '0;
          w_onehot_nxt = '0;
          if (r_rr) w_ptr_nxt = (r_idx == '0) ? W'(N - 1) : r_idx - W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign gnt_vld    = r_vld;
  assign gnt_idx    = r_idx;
  assign gnt_onehot = r_onehot;
  assign busy       = r_vld;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed scoreboard bench for prio_arbiter: N=8 in both modes plus an N=4
// fixed-priority instance checked against the 4:2 encoder truth table.
module tb_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic       ack;
  logic       gnt_vld;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       busy;

  logic [3:0] req4;
  logic       mode4;
  logic       ack4;
  logic       gnt_vld4;
  logic [1:0] gnt_idx4;
  logic [3:0] gnt_onehot4;
  logic       busy4;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_q4[$];

  always #5 clk = ~clk;

  prio_arbiter #(.N(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .gnt_ack(ack),
    .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot), .busy(busy)
  );

  prio_arbiter #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .mode(mode4), .gnt_ack(ack4),
    .gnt_vld(gnt_vld4), .gnt_idx(gnt_idx4), .gnt_onehot(gnt_onehot4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, "_vld"},    32'(gnt_vld),    32'd0);
    chk({tag, "_idx"},    32'(gnt_idx),    32'd0);
    chk({tag, "_onehot"}, 32'(gnt_onehot), 32'd0);
    chk({tag, "_busy"},   32'(busy),       32'd0);
  endtask

  // Wait (bounded) for a grant, then compare it against the scoreboard head
  task automatic wait_grant8(input string tag, output int cyc);
    int e;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (gnt_vld !== 1'b1 && cyc < 20);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
    chk({tag, "_vld"},    32'(gnt_vld),    32'd1);
    chk({tag, "_idx"},    32'(gnt_idx),    32'(e));
    chk({tag, "_onehot"}, 32'(gnt_onehot), 32'(8'd1 << e));
    chk({tag, "_busy"},   32'(busy),       32'd1);
  endtask

  // Ack the current grant; the following cycle must be an idle bubble
  task automatic ack8(input string tag, input logic [7:0] next_req);
    ack = 1'b1;
    req = next_req;
    step();
    ack = 1'b0;
    chk_idle8({tag, "_bubble"});
  endtask

  initial begin
    int c;
    int seq3[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int seq4[4] = '{7, 0, 7, 0};
    rst   = 1'b1;
    req   = '0;
    mode  = 1'b0;
    ack   = 1'b0;
    req4  = '0;
    mode4 = 1'b0;
    ack4  = 1'b0;
    step();
    step();
    chk_idle8("reset");
    chk("reset4_vld", 32'(gnt_vld4), 32'd0);
    rst = 1'b0;
    step();

    // Fixed priority picks the highest set bit, one clock after the request
    req = 8'b0010_0110;
    exp_q.push_back(5);
    wait_grant8("t1", c);
    chk("t1_lat", 32'(c), 32'd1);

    // Grant holds without ack even when req changes
    for (int i = 0; i < 10; i++) begin
      if (i == 5) req = 8'h80;
      step();
      chk("t2_hold_vld", 32'(gnt_vld), 32'd1);
      chk("t2_hold_idx", 32'(gnt_idx), 32'd5);
    end
    exp_q.push_back(7);
    ack8("t2", 8'h80);
    wait_grant8("t2_next", c);
    chk("t2_lat", 32'(c), 32'd1);
    ack8("t2_end", 8'h00);

    // Round-robin over all lines, wrapping after 0
    mode = 1'b1;
    req  = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(seq3[i]);
      wait_grant8("t3", c);
      chk("t3_lat", 32'(c), 32'd1);
      ack8("t3", (i == 8) ? 8'h00 : 8'hFF);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk_idle8("t4_reset");

    // Round-robin skips idle lines and wraps 0 -> N-1
    req = 8'b1000_0001;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(seq4[i]);
      wait_grant8("t4", c);
      ack8("t4", (i == 3) ? 8'h00 : 8'h81);
    end

    // One RR grant leaves ptr at 6
    req = 8'hFF;
    exp_q.push_back(7);
    wait_grant8("t6a", c);
    ack8("t6a", 8'h00);

    // No requests: outputs stay 0 and acks are ignored
    for (int i = 0; i < 20; i++) begin
      ack = (i % 2 == 1);
      step();
      chk_idle8("t5");
    end
    ack = 1'b0;

    // ptr survived the idle acks, so the next grant is 6; reset mid-grant drops it
    req = 8'hFF;
    exp_q.push_back(6);
    wait_grant8("t6b", c);
    #2;
    rst = 1'b1;
    #1;
    chk_idle8("t6_async");
    step();
    rst = 1'b0;
    exp_q.push_back(7);
    wait_grant8("t6_after", c);
    ack8("t6_after", 8'h00);

    // N=4 fixed priority reproduces the 4:2 encoder truth table
    for (int k = 3; k >= 0; k--) begin
      for (int r = 0; r < 2; r++) begin
        logic [3:0] lo;
        int e4;
        lo   = 4'(($urandom() & 32'hF) & ((32'd1 << k) - 1));
        req4 = 4'(32'd1 << k) | lo;
        exp_q4.push_back(k);
        step();
        e4 = (exp_q4.size() != 0) ? exp_q4.pop_front() : -1;
        chk("t7_vld",    32'(gnt_vld4),    32'd1);
        chk("t7_idx",    32'(gnt_idx4),    32'(e4));
        chk("t7_onehot", 32'(gnt_onehot4), 32'(4'd1 << e4));
        ack4 = 1'b1;
        req4 = '0;
        step();
        ack4 = 1'b0;
        chk("t7_bubble", 32'(gnt_vld4), 32'd0);
      end
    end

    chk("scoreboard_empty", 32'(exp_q.size() + exp_q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
